load_use_scoreboard: RTL and testbench

Parametrised successor of the single-cycle load-use hazard detector. It keeps a per-register countdown scoreboard of pending multi-cycle results from loads, multi-cycle ALU ops and long-latency memories, so one block covers any producer latency up to MAX_LAT. It sits in the ID stage. It checks the instruction in ID against in-flight producers and raises `stall` to freeze PC/IF_ID and inject a bubble into ID_EX. It also rolls back the scoreboard entry of an instruction squashed by a branch flush.

---
 rtl/load_use_scoreboard.sv | 101 ++++++++++
 tb/tb_load_use_scoreboard.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_use_scoreboard.sv
// Per-register countdown scoreboard for multi-cycle producers; stalls the ID stage on hazards.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module load_use_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 3,
  parameter int CW      = $clog2(MAX_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [CW-1:0]     id_lat,
  input  logic              flush,
  output logic              stall,
  output logic [15:0]       stall_count
);

  localparam int            NREG      = 1 << REG_AW;
  localparam logic [CW-1:0] MAX_LAT_C = CW'(MAX_LAT);

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  logic [CW-1:0]     cnt_q [NREG];
  logic [CW-1:0]     cnt_d [NREG];
  logic              last_valid_q, last_valid_d;
  logic [REG_AW-1:0] last_rd_q, last_rd_d;
  logic [CW-1:0]     last_prev_q, last_prev_d;

  logic          hz1, hz2, acc, wr;
  logic [CW-1:0] lat_clip;

  assign hz1      = id_rs1_used && (id_rs1 != '0) && (cnt_q[id_rs1] != '0);
  assign hz2      = id_rs2_used && (id_rs2 != '0) && (cnt_q[id_rs2] != '0);
  assign stall    = id_valid && !flush && (hz1 || hz2);
  assign acc      = id_valid && !stall && !flush;
  assign wr       = acc && id_regwrite && (id_rd != '0);
  assign lat_clip = (id_lat > MAX_LAT_C) ? MAX_LAT_C : id_lat;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = sat_dec(cnt_q[r]);
    end
    // A squashed writer hands its entry back to the older producer it displaced.
    if (flush && last_valid_q) begin
      cnt_d[last_rd_q] = sat_dec(last_prev_q);
    end
    if (wr) begin
      cnt_d[id_rd] = lat_clip;
    end
    last_valid_d = wr;
    last_rd_d    = wr ? id_rd : last_rd_q;
    last_prev_d  = wr ? sat_dec(cnt_q[id_rd]) : last_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      last_valid_q <= 1'b0;
      last_rd_q    <= '0;
      last_prev_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      last_valid_q <= last_valid_d;
      last_rd_q    <= last_rd_d;
      last_prev_q  <= last_prev_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Self-checking bench for load_use_scoreboard: directed hazard scenarios plus random traffic
// checked against a ready-time model (absolute cycle at which each register becomes usable).
module tb_load_use_scoreboard;
  localparam int REG_AW  = 5;
  localparam int MAX_LAT = 3;
  localparam int CW      = 2;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid = 1'b0;
  logic [REG_AW-1:0] id_rs1 = '0;
  logic [REG_AW-1:0] id_rs2 = '0;
  logic              id_rs1_used = 1'b0;
  logic              id_rs2_used = 1'b0;
  logic              id_regwrite = 1'b0;
  logic [REG_AW-1:0] id_rd = '0;
  logic [CW-1:0]     id_lat = '0;
  logic              flush = 1'b0;
  logic              stall;
  logic [15:0]       stall_count;

  load_use_scoreboard #(.REG_AW(REG_AW), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_regwrite(id_regwrite), .id_rd(id_rd), .id_lat(id_lat), .flush(flush),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  // Model: ready[r] = first edge-count at which a reader of r may be accepted.
  int now;
  int ready [32];
  bit lv;
  int lrd;
  int lprev;
  int scnt;

  function automatic void model_reset();
    now = 0;
    for (int r = 0; r < 32; r++) ready[r] = 0;
    lv = 1'b0; lrd = 0; lprev = 0; scnt = 0;
  endfunction

  function automatic bit model_stall();
    bit h1, h2;
    h1 = id_rs1_used && (id_rs1 != 0) && (now < ready[id_rs1]);
    h2 = id_rs2_used && (id_rs2 != 0) && (now < ready[id_rs2]);
    return id_valid && !flush && (h1 || h2);
  endfunction

  function automatic int exp_cnt();
    return CNT_EN ? scnt : 0;
  endfunction

  task automatic tick();
    bit s, acc;
    int l;
    s   = model_stall();
    acc = id_valid && !s && !flush;
    if (s && scnt < 65535) scnt++;
    if (flush && lv) ready[lrd] = lprev;
    if (acc && id_regwrite && id_rd != 0) begin
      l     = (int'(id_lat) > MAX_LAT) ? MAX_LAT : int'(id_lat);
      lprev = ready[id_rd];
      lrd   = int'(id_rd);
      lv    = 1'b1;
      ready[id_rd] = now + 1 + l;
    end else begin
      lv = 1'b0;
    end
    @(posedge clk);
    now++;
    #1;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    flush    = 1'b0;
    repeat (n) tick();
  endtask

  // Presents one instruction and holds it until the model accepts it (bounded).
  task automatic issue(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                       input bit wr, input logic [4:0] rd, input logic [1:0] lat, input bit fl,
                       output int n_obs, output int n_exp);
    bit s_exp;
    id_valid = 1'b1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_regwrite = wr; id_rd = rd; id_lat = lat; flush = fl;
    n_obs = 0; n_exp = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      s_exp = model_stall();
      if (stall === 1'b1) n_obs++;
      if (s_exp) n_exp++;
      tick();
      if (!s_exp) break;
    end
  endtask

  task automatic test_reset();
    int o, e;
    rst_n = 1'b0;
    id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    #12;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    total++;
    if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", stall_count); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(1);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd3, 2'd2, 0, o, e);
    issue(5'd3, 1, 5'd0, 0, 0, 5'd0, 2'd0, 0, o, e);
    total++;
    if (o !== 2) begin bad++; $display("FAIL post_reset_l2 got=%0d want=2", o); end
  endtask

  task automatic test_counter_four();
    int o, e, want;
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd11, 2'd3, 0, o, e);
    issue(5'd11, 1, 5'd0, 0, 0, 5'd0, 2'd0, 0, o, e);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd12, 2'd1, 0, o, e);
    issue(5'd0, 0, 5'd12, 1, 0, 5'd0, 2'd0, 0, o, e);
    idle(1);
    @(negedge clk);
    want = CNT_EN ? 4 : 0;
    total++;
    if (int'(stall_count) !== want) begin
      bad++; $display("FAIL counter_four got=%0d want=%0d", stall_count, want);
    end
  endtask

  task automatic test_load_use_l1();
    int o, e;
    idle(4);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd5, 2'd1, 0, o, e);
    issue(5'd5, 1, 5'd0, 0, 1, 5'd6, 2'd0, 0, o, e);
    total++;
    if (o !== 1) begin bad++; $display("FAIL load_use_l1 got=%0d want=1", o); end
  endtask

  task automatic test_l3_distance();
    int o, e;
    idle(4);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd6, 2'd3, 0, o, e);
    issue(5'd0, 0, 5'd6, 1, 0, 5'd0, 2'd0, 0, o, e);
    total++;
    if (o !== 3) begin bad++; $display("FAIL l3_adjacent got=%0d want=3", o); end
    idle(4);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd6, 2'd3, 0, o, e);
    issue(5'd0, 0, 5'd0, 0, 0, 5'd0, 2'd0, 0, o, e);
    issue(5'd0, 0, 5'd0, 0, 0, 5'd0, 2'd0, 0, o, e);
    issue(5'd6, 1, 5'd0, 0, 0, 5'd0, 2'd0, 0, o, e);
    total++;
    if (o !== 1) begin bad++; $display("FAIL l3_distance3 got=%0d want=1", o); end
  endtask

  task automatic test_x0_unused();
    int o, e;
    idle(4);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd0, 2'd3, 0, o, e);
    issue(5'd0, 1, 5'd0, 1, 0, 5'd0, 2'd0, 0, o, e);
    total++;
    if (o !== 0) begin bad++; $display("FAIL x0_read got=%0d want=0", o); end
    issue(5'd0, 0, 5'd0, 0, 1, 5'd8, 2'd3, 0, o, e);
    issue(5'd0, 0, 5'd8, 0, 0, 5'd0, 2'd0, 0, o, e);
    total++;
    if (o !== 0) begin bad++; $display("FAIL rs2_unused got=%0d want=0", o); end
    issue(5'd8, 1, 5'd0, 0, 0, 5'd0, 2'd0, 0, o, e);
    total++;
    if (o !== 2) begin bad++; $display("FAIL unused_keeps_cnt got=%0d want=2", o); end
  endtask

  task automatic test_overwrite();
    int o, e;
    idle(4);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd7, 2'd3, 0, o, e);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd7, 2'd0, 0, o, e);
    issue(5'd7, 1, 5'd7, 1, 0, 5'd0, 2'd0, 0, o, e);
    total++;
    if (o !== 0) begin bad++; $display("FAIL overwrite got=%0d want=0", o); end
  endtask

  task automatic test_flush_rollback();
    int o, e;
    idle(4);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd9, 2'd3, 0, o, e);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd9, 2'd1, 0, o, e);
    issue(5'd9, 1, 5'd0, 0, 1, 5'd9, 2'd3, 1, o, e);
    total++;
    if (o !== 0) begin bad++; $display("FAIL flush_no_stall got=%0d want=0", o); end
    issue(5'd9, 1, 5'd0, 0, 0, 5'd0, 2'd0, 0, o, e);
    total++;
    if (o !== 1) begin bad++; $display("FAIL flush_rollback got=%0d want=1", o); end
  endtask

  task automatic test_random();
    int o, e;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        id_valid = 1'b0;
        flush    = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL rand_bubble[%0d] got=%b want=0", i, stall); end
        tick();
      end else begin
        issue(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL rand_instr[%0d] stalls got=%0d want=%0d", i, o, e); end
      end
    end
    @(negedge clk);
    total++;
    if (int'(stall_count) !== exp_cnt()) begin
      bad++; $display("FAIL rand_stall_count got=%0d want=%0d", stall_count, exp_cnt());
    end
  endtask

  task automatic test_reset_mid_stall();
    int o, e;
    bit s_exp;
    idle(4);
    issue(5'd0, 0, 5'd0, 0, 1, 5'd10, 2'd3, 0, o, e);
    id_valid = 1'b1; id_rs1 = 5'd10; id_rs1_used = 1'b1; id_rs2_used = 1'b0;
    id_regwrite = 1'b0; flush = 1'b0;
    @(negedge clk);
    s_exp = model_stall();
    total++;
    if (stall !== s_exp) begin bad++; $display("FAIL pre_reset_stall got=%b want=%b", stall, s_exp); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL mid_reset_stall got=%b want=0", stall); end
    total++;
    if (stall_count !== 16'd0) begin bad++; $display("FAIL mid_reset_count got=%0d want=0", stall_count); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_counter_four();
    test_load_use_l1();
    test_l3_distance();
    test_x0_unused();
    test_overwrite();
    test_flush_rollback();
    test_random();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
